// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, instruction field
// positions and the control FSM state encoding.
package seq_pkg;

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_AND  = 6'h03;
    localparam logic [5:0] OP_OR   = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LD   = 6'h10;
    localparam logic [5:0] OP_ST   = 6'h11;
    localparam logic [5:0] OP_JMP  = 6'h20;
    localparam logic [5:0] OP_BEQ  = 6'h21;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam int OP_HI  = 23;
    localparam int OP_LO  = 18;
    localparam int RS1_HI = 17;
    localparam int RS1_LO = 16;
    localparam int RS2_HI = 15;
    localparam int RS2_LO = 14;
    localparam int RD_HI  = 13;
    localparam int RD_LO  = 12;
    localparam int IMM_HI = 11;
    localparam int IMM_LO = 0;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        MEM,
        WB,
        HALT
    } state_t;

endpackage

// File: rtl/op_decode.sv
// Combinational opcode classifier: maps the 6-bit opcode onto the class flags
// the sequencer FSM steers on. NOP raises no flag and is not illegal.
import seq_pkg::*;

module op_decode (
    input  logic [5:0] op,
    output logic       is_alu,
    output logic       is_imm,
    output logic       is_ld,
    output logic       is_st,
    output logic       is_jmp,
    output logic       is_beq,
    output logic       is_halt,
    output logic       is_illegal
);

    always_comb begin
        is_alu     = 1'b0;
        is_imm     = 1'b0;
        is_ld      = 1'b0;
        is_st      = 1'b0;
        is_jmp     = 1'b0;
        is_beq     = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (op)
            OP_NOP:                        ;
            OP_ADD, OP_SUB, OP_AND, OP_OR: is_alu  = 1'b1;
            OP_ADDI:                       is_imm  = 1'b1;
            OP_LD:                         is_ld   = 1'b1;
            OP_ST:                         is_st   = 1'b1;
            OP_JMP:                        is_jmp  = 1'b1;
            OP_BEQ:                        is_beq  = 1'b1;
            OP_HALT:                       is_halt = 1'b1;
            default:                       is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instruction_sequencer.sv
// Multi-cycle control unit: fetch, decode, execute, memory and writeback sequencing for the 24-bit core.
// Build option SEQ_ILLEGAL_TRAP_EN: an unknown opcode halts the core instead of running as a NOP.
import seq_pkg::*;

module instruction_sequencer #(
    parameter int PC_W    = 12,
    parameter int INSTR_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    input  logic               dmem_ack,
    output logic [1:0]         rf_rs1,
    output logic [1:0]         rf_rs2,
    output logic [1:0]         rf_rd,
    output logic               rf_we,
    output logic               wb_sel,
    output logic [5:0]         alu_op,
    output logic               alu_src_imm,
    input  logic               alu_zero,
    output logic [11:0]        imm,
    output logic [PC_W-1:0]    pc,
    output logic               halted,
    output logic               illegal
);

    // state   | meaning
    // FETCH   | imem_req held at pc until imem_ack, then IR loaded
    // DECODE  | pc advances, instruction classified
    // EXECUTE | alu_op driven; jumps and branches resolve here
    // MEM     | dmem_req held until dmem_ack
    // WB      | single-cycle rf_we strobe
    // HALT    | stopped until reset

    state_t             state;
    logic [INSTR_W-1:0] ir;
    logic is_alu, is_imm, is_ld, is_st, is_jmp, is_beq, is_halt, is_illegal;
    logic go_exec;

    op_decode u_op_decode (
        .op        (ir[OP_HI:OP_LO]),
        .is_alu    (is_alu),
        .is_imm    (is_imm),
        .is_ld     (is_ld),
        .is_st     (is_st),
        .is_jmp    (is_jmp),
        .is_beq    (is_beq),
        .is_halt   (is_halt),
        .is_illegal(is_illegal)
    );

    assign imem_addr   = pc;
    assign rf_rs1      = ir[RS1_HI:RS1_LO];
    assign rf_rs2      = ir[RS2_HI:RS2_LO];
    assign rf_rd       = ir[RD_HI:RD_LO];
    assign imm         = ir[IMM_HI:IMM_LO];
    assign alu_src_imm = is_imm | is_ld | is_st;
    assign go_exec     = is_alu | is_imm | is_ld | is_st | is_jmp | is_beq;

    // Strobes are registered from the state being entered, so each is high
    // exactly while the FSM sits in the matching state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= '0;
            ir       <= '0;
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            rf_we    <= 1'b0;
            wb_sel   <= 1'b0;
            alu_op   <= '0;
            halted   <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            rf_we    <= 1'b0;
            wb_sel   <= 1'b0;
            alu_op   <= '0;
            case (state)
                FETCH: begin
                    if (imem_req && imem_ack) begin
                        ir    <= imem_rdata;
                        state <= DECODE;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                DECODE: begin
                    pc <= pc + PC_W'(1);
                    if (is_illegal) illegal <= 1'b1;
                    if (is_halt) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else if (is_illegal) begin
`ifdef SEQ_ILLEGAL_TRAP_EN
                        state  <= HALT;
                        halted <= 1'b1;
`else
                        state    <= FETCH;
                        imem_req <= 1'b1;
`endif
                    end else if (go_exec) begin
                        state  <= EXECUTE;
                        alu_op <= is_beq ? OP_SUB : ir[OP_HI:OP_LO];
                    end else begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                EXECUTE: begin
                    if (is_jmp || is_beq) begin
                        if (is_jmp || alu_zero) pc <= PC_W'(imm);
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end else if (is_ld || is_st) begin
                        state    <= MEM;
                        dmem_req <= 1'b1;
                        dmem_we  <= is_st;
                    end else begin
                        state <= WB;
                        rf_we <= 1'b1;
                    end
                end
                MEM: begin
                    if (dmem_ack) begin
                        if (is_ld) begin
                            state  <= WB;
                            rf_we  <= 1'b1;
                            wb_sel <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            imem_req <= 1'b1;
                        end
                    end else begin
                        dmem_req <= 1'b1;
                        dmem_we  <= is_st;
                    end
                end
                WB: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                HALT: state <= HALT;
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule
